snake_grid_reader: RTL and testbench

// Game-side read agent for the 2-bit-per-cell playfield memory; the reading counterpart of the

---
 rtl/snake_grid_pkg.sv | 23 ++
 rtl/grid_addr_step.sv | 24 ++
 rtl/snake_grid_reader.sv | 235 +++++++++++++++++++++++
 tb/tb_snake_grid_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_grid_pkg.sv
// Shared definitions for the playfield memory agents: cell codes, request
// opcodes and the read-agent FSM state type.
package snake_grid_pkg;

    // Cell contents stored in the 2-bit-per-cell playfield memory
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SNAKE = 2'b01;
    localparam logic [1:0] CELL_FOOD  = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    // Request opcodes seen on req_op
    localparam logic OP_PROBE = 1'b0;
    localparam logic OP_SCAN  = 1'b1;

    // Read-agent FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PROBE_RD = 2'd1,
        SCAN_RUN = 2'd2,
        RESP     = 2'd3
    } reader_state_e;

endpackage

// File: rtl/grid_addr_step.sv
// Row-major playfield address increment: x advances first, and when x wraps
// back to 0 the row advances; the last row wraps back to row 0.
module grid_addr_step
    import snake_grid_pkg::*;
#(
    parameter int XB = 4,
    parameter int YB = 4
) (
    input  logic [XB-1:0] x_in,
    input  logic [YB-1:0] y_in,
    output logic [XB-1:0] x_out,
    output logic [YB-1:0] y_out
);

    // Next cell in row-major order with wrap on both axes
    always_comb begin
        x_out = x_in + XB'(1);
        y_out = y_in;
        if (x_in == {XB{1'b1}}) begin
            y_out = y_in + YB'(1);
        end
    end

endmodule

// File: rtl/snake_grid_reader.sv
// Game-side read agent for the playfield memory. Serves single-cell PROBE
// requests and SCAN requests that search row-major for the first empty cell,
// issuing one pipelined read per cycle and tracking in-flight reads with a
// RD_LAT-deep tag shift register.
module snake_grid_reader
    import snake_grid_pkg::*;
#(
    parameter int GRID_XB = 4,
    parameter int GRID_YB = 4,
    parameter int CELL_W  = 2,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [GRID_XB-1:0] req_x,
    input  logic [GRID_YB-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [CELL_W-1:0]  rsp_data,
    output logic [GRID_XB-1:0] rsp_x,
    output logic [GRID_YB-1:0] rsp_y,
    output logic               rsp_found,
    output logic               mem_rd_en,
    output logic [GRID_XB-1:0] mem_x,
    output logic [GRID_YB-1:0] mem_y,
    input  logic [CELL_W-1:0]  mem_data
);

    // One extra bit so that a full-grid count is distinguishable from zero
    localparam int                 CNT_W      = GRID_XB + GRID_YB + 1;
    localparam logic [CNT_W-1:0]   CELL_COUNT = CNT_W'(2 ** (GRID_XB + GRID_YB));
    localparam logic [CELL_W-1:0]  EMPTY_CODE = CELL_W'(CELL_EMPTY);

    reader_state_e        state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CELL_W-1:0]    rsp_data_q, rsp_data_d;
    logic [GRID_XB-1:0]   rsp_x_q, rsp_x_d;
    logic [GRID_YB-1:0]   rsp_y_q, rsp_y_d;
    logic                 rsp_found_q, rsp_found_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic [GRID_XB-1:0]   mem_x_q, mem_x_d;
    logic [GRID_YB-1:0]   mem_y_q, mem_y_d;
    logic [GRID_XB-1:0]   start_x_q, start_x_d;
    logic [GRID_YB-1:0]   start_y_q, start_y_d;
    logic [CNT_W-1:0]     issued_q, issued_d;
    logic [CNT_W-1:0]     returned_q, returned_d;

    logic [RD_LAT-1:0]    pipe_vld_q, pipe_vld_d;
    logic [GRID_XB-1:0]   pipe_x_q [RD_LAT];
    logic [GRID_XB-1:0]   pipe_x_d [RD_LAT];
    logic [GRID_YB-1:0]   pipe_y_q [RD_LAT];
    logic [GRID_YB-1:0]   pipe_y_d [RD_LAT];

    logic                 flush;
    logic                 ret_vld;
    logic [GRID_XB-1:0]   ret_x;
    logic [GRID_YB-1:0]   ret_y;
    logic [GRID_XB-1:0]   next_x;
    logic [GRID_YB-1:0]   next_y;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_found = rsp_found_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_x     = mem_x_q;
    assign mem_y     = mem_y_q;

    // The oldest tag lines up with the read data currently on mem_data
    assign ret_vld = pipe_vld_q[RD_LAT-1];
    assign ret_x   = pipe_x_q[RD_LAT-1];
    assign ret_y   = pipe_y_q[RD_LAT-1];

    grid_addr_step #(
        .XB(GRID_XB),
        .YB(GRID_YB)
    ) u_step (
        .x_in (mem_x_q),
        .y_in (mem_y_q),
        .x_out(next_x),
        .y_out(next_y)
    );

    // FSM next-state, read issue and response capture
    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_found_d = rsp_found_q;
        mem_rd_en_d = 1'b0;
        mem_x_d     = mem_x_q;
        mem_y_d     = mem_y_q;
        start_x_d   = start_x_q;
        start_y_d   = start_y_q;
        issued_d    = issued_q;
        returned_d  = returned_q;
        flush       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    start_x_d   = req_x;
                    start_y_d   = req_y;
                    mem_rd_en_d = 1'b1;
                    mem_x_d     = req_x;
                    mem_y_d     = req_y;
                    issued_d    = CNT_W'(1);
                    returned_d  = '0;
                    state_d     = (req_op == OP_SCAN) ? SCAN_RUN : PROBE_RD;
                end
            end

            PROBE_RD: begin
                if (ret_vld) begin
                    rsp_data_d  = mem_data;
                    rsp_x_d     = ret_x;
                    rsp_y_d     = ret_y;
                    rsp_found_d = 1'b1;
                    flush       = 1'b1;
                    state_d     = RESP;
                end
            end

            SCAN_RUN: begin
                if (ret_vld && (mem_data == EMPTY_CODE)) begin
                    rsp_data_d  = EMPTY_CODE;
                    rsp_x_d     = ret_x;
                    rsp_y_d     = ret_y;
                    rsp_found_d = 1'b1;
                    flush       = 1'b1;
                    state_d     = RESP;
                end else begin
                    if (ret_vld) begin
                        returned_d = returned_q + CNT_W'(1);
                    end
                    if (ret_vld && (returned_d == CELL_COUNT)) begin
                        rsp_data_d  = mem_data;
                        rsp_x_d     = start_x_q;
                        rsp_y_d     = start_y_q;
                        rsp_found_d = 1'b0;
                        flush       = 1'b1;
                        state_d     = RESP;
                    end else if (issued_q != CELL_COUNT) begin
                        mem_rd_en_d = 1'b1;
                        mem_x_d     = next_x;
                        mem_y_d     = next_y;
                        issued_d    = issued_q + CNT_W'(1);
                    end
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // Shift the issued-read tags along; a flush drops every in-flight read
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = mem_rd_en_q;
        pipe_x_d[0]   = mem_x_q;
        pipe_y_d[0]   = mem_y_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_x_d[i]   = pipe_x_q[i-1];
            pipe_y_d[i]   = pipe_y_q[i-1];
        end
        if (flush) begin
            pipe_vld_d = '0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_found_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
            start_x_q   <= '0;
            start_y_q   <= '0;
            issued_q    <= '0;
            returned_q  <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_found_q <= rsp_found_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_x_q     <= mem_x_d;
            mem_y_q     <= mem_y_d;
            start_x_q   <= start_x_d;
            start_y_q   <= start_y_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_x_q[i] <= pipe_x_d[i];
                pipe_y_q[i] <= pipe_y_d[i];
            end
        end
    end

endmodule

// File: tb/tb_snake_grid_reader.sv
// Testbench for snake_grid_reader: two instances (RD_LAT=1 and RD_LAT=3)
// share a behavioural playfield memory; every response is compared with a
// reference computed directly from the grid contents.
module tb_snake_grid_reader;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_op;
    logic [1:0][3:0] req_x;
    logic [1:0][3:0] req_y;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [1:0][1:0] rsp_data;
    logic [1:0][3:0] rsp_x;
    logic [1:0][3:0] rsp_y;
    logic [1:0]      rsp_found;
    logic [1:0]      mem_rd_en;
    logic [1:0][3:0] mem_x;
    logic [1:0][3:0] mem_y;
    logic [1:0][1:0] mem_data;

    logic [1:0] grid [16][16];
    logic [1:0] mpipe [2][3];
    logic [7:0] rd_addr [2][4096];
    int         rd_cnt [2];
    int         check_cnt = 0;
    int         pass_cnt  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        snake_grid_reader #(
            .GRID_XB(4),
            .GRID_YB(4),
            .CELL_W (2),
            .RD_LAT ((g == 0) ? 1 : 3)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_op   (req_op[g]),
            .req_x    (req_x[g]),
            .req_y    (req_y[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_data (rsp_data[g]),
            .rsp_x    (rsp_x[g]),
            .rsp_y    (rsp_y[g]),
            .rsp_found(rsp_found[g]),
            .mem_rd_en(mem_rd_en[g]),
            .mem_x    (mem_x[g]),
            .mem_y    (mem_y[g]),
            .mem_data (mem_data[g])
        );
    end

    assign mem_data[0] = mpipe[0][0];
    assign mem_data[1] = mpipe[1][2];

    // Playfield memory with per-lane read latency, plus a log of every read
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (mem_rd_en[l]) begin
                rd_addr[l][rd_cnt[l] % 4096] <= {mem_y[l], mem_x[l]};
                rd_cnt[l] <= rd_cnt[l] + 1;
                mpipe[l][0] <= grid[mem_y[l]][mem_x[l]];
            end else begin
                mpipe[l][0] <= 2'($urandom);
            end
            mpipe[l][1] <= mpipe[l][0];
            mpipe[l][2] <= mpipe[l][1];
        end
    end

    function automatic int latOf(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    // Reference search: walk cells in row-major order from the start point
    function automatic void scanModel(input int sx, input int sy, output int k,
                                      output bit found, output int fx, output int fy,
                                      output logic [1:0] last);
        int lin;
        found = 1'b0;
        k     = 256;
        fx    = sx;
        fy    = sy;
        last  = 2'b00;
        for (int i = 0; i < 256; i++) begin
            lin  = (sy * 16 + sx + i) % 256;
            last = grid[lin / 16][lin % 16];
            if (last == 2'b00) begin
                found = 1'b1;
                k     = i + 1;
                fx    = lin % 16;
                fy    = lin / 16;
                break;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: no empty cell; 1: one empty cell; 2: sparse empties; 3: dense empties
    task automatic fillGrid(input int mode);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                grid[y][x] = 2'($urandom_range(1, 3));
                if (mode == 2 && $urandom_range(0, 19) == 0) grid[y][x] = 2'b00;
                if (mode == 3 && $urandom_range(0, 2) == 0) grid[y][x] = 2'b00;
            end
        end
        if (mode == 1) grid[$urandom_range(0, 15)][$urandom_range(0, 15)] = 2'b00;
    endtask

    task automatic fillAll(input logic [1:0] v);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                grid[y][x] = v;
    endtask

    task automatic waitReady(input int l, input string tag);
        int n = 0;
        while (!req_ready[l] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(req_ready[l]), 64'd1);
    endtask

    // Issue one request on a lane, check the response, optionally hold it
    // under backpressure (and poke a request that must be ignored), then retire it
    task automatic applyStimulus(input int l, input bit op, input int x, input int y,
                                 input int hold, input bit poke);
        int k, fx, fy, lat_exp, exp_reads, base, edges, n_addr;
        bit found;
        logic [1:0] exp_data;
        logic [18:0] snap;
        string pfx;
        pfx = $sformatf("L%0d %s(%0d,%0d)", l, op ? "scan" : "probe", x, y);
        if (op) begin
            scanModel(x, y, k, found, fx, fy, exp_data);
            if (found) exp_data = 2'b00;
            lat_exp   = k + latOf(l);
            exp_reads = found ? ((k + latOf(l) > 256) ? 256 : k + latOf(l)) : 256;
        end else begin
            k = 1; found = 1'b1; fx = x; fy = y;
            exp_data  = grid[y][x];
            lat_exp   = 1 + latOf(l);
            exp_reads = 1;
        end
        @(negedge clk);
        waitReady(l, {pfx, " ready"});
        base = rd_cnt[l];
        req_valid[l] = 1'b1;
        req_op[l]    = op;
        req_x[l]     = 4'(x);
        req_y[l]     = 4'(y);
        @(negedge clk);
        req_valid[l] = 1'b0;
        req_x[l]     = 4'($urandom);
        req_y[l]     = 4'($urandom);
        edges = 0;
        while (!rsp_valid[l] && edges < lat_exp + 40) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({pfx, " latency"}, 64'(edges), 64'(lat_exp));
        checkOutput({pfx, " data"}, 64'(rsp_data[l]), 64'(exp_data));
        checkOutput({pfx, " x"}, 64'(rsp_x[l]), 64'(fx));
        checkOutput({pfx, " y"}, 64'(rsp_y[l]), 64'(fy));
        checkOutput({pfx, " found"}, 64'(rsp_found[l]), 64'(found));
        checkOutput({pfx, " ready low"}, 64'(req_ready[l]), 64'd0);
        checkOutput({pfx, " reads"}, 64'(rd_cnt[l] - base), 64'(exp_reads));
        n_addr = (k < 6) ? k : 6;
        for (int i = 0; i < n_addr; i++) begin
            checkOutput($sformatf("%s addr%0d", pfx, i),
                        64'(rd_addr[l][(base + i) % 4096]), 64'((y * 16 + x + i) % 256));
        end
        snap = {rsp_valid[l], rsp_data[l], rsp_x[l], rsp_y[l], rsp_found[l], req_ready[l], 4'h0};
        if (poke) begin
            req_valid[l] = 1'b1;
            req_op[l]    = 1'($urandom);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s hold%0d", pfx, i),
                        64'({rsp_valid[l], rsp_data[l], rsp_x[l], rsp_y[l], rsp_found[l],
                             req_ready[l], 4'h0}), 64'(snap));
        end
        req_valid[l] = 1'b0;
        checkOutput({pfx, " no reads in hold"}, 64'(rd_cnt[l] - base), 64'(exp_reads));
        rsp_ready[l] = 1'b1;
        @(negedge clk);
        rsp_ready[l] = 1'b0;
        checkOutput({pfx, " retire"}, 64'({rsp_valid[l], req_ready[l]}), 64'b01);
        if (poke) begin
            repeat (3) @(negedge clk);
            checkOutput({pfx, " poke ignored"}, 64'({rd_cnt[l] - base, rsp_valid[l], req_ready[l]}),
                        64'({exp_reads, 1'b0, 1'b1}));
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen, base;
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '0;
        fillGrid(3);

        $display("[TB] reset checks");
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            checkOutput($sformatf("L%0d reset outputs", l),
                        64'({req_ready[l], rsp_valid[l], rsp_found[l], mem_rd_en[l], rsp_data[l],
                             rsp_x[l], rsp_y[l], mem_x[l], mem_y[l]}), 64'd0);
        end
        reset = 1'b0;
        checkOutput("ready still low at release", 64'(req_ready), 64'd0);
        @(negedge clk);
        checkOutput("ready after release", 64'({req_ready, rsp_valid}), 64'b1100);

        $display("[TB] directed probe / scan on both latencies");
        for (int l = 0; l < 2; l++) begin
            fillGrid(3);
            grid[9][5] = 2'b10;
            applyStimulus(l, 1'b0, 5, 9, 0, 1'b0);
            fillAll(2'b01);
            grid[0][1] = 2'b00;
            applyStimulus(l, 1'b1, 14, 15, 0, 1'b0);
            fillAll(2'b01);
            applyStimulus(l, 1'b1, 3, 3, 0, 1'b0);
        end

        $display("[TB] backpressure with ignored request");
        fillGrid(2);
        applyStimulus(0, 1'b0, 7, 2, 10, 1'b1);
        applyStimulus(1, 1'b1, 0, 0, 10, 1'b1);

        $display("[TB] reset during scan");
        fillAll(2'b01);
        @(negedge clk);
        waitReady(0, "abort ready");
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        req_x[0]     = 4'd0;
        req_y[0]     = 4'd0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = rd_cnt[0];
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        checkOutput("abort no rsp_valid", 64'(seen), 64'd0);
        checkOutput("abort no reads", 64'(rd_cnt[0] - base), 64'd0);
        fillGrid(3);
        grid[4][11] = 2'b11;
        applyStimulus(0, 1'b0, 11, 4, 0, 1'b0);

        $display("[TB] randomized requests");
        for (int it = 0; it < 40; it++) begin
            fillGrid($urandom_range(0, 3));
            applyStimulus(it % 2, 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
